// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt block: register offsets and default pin count.
// Offsets must stay aligned with the GPIO controller's address constants.
package gpio_irq_pkg;

  localparam int unsigned GPIO_WIDTH = 32;
  localparam int unsigned DEB_HIST   = 3;

  typedef enum logic [1:0] {
    REG_EN    = 2'b00,
    REG_EDGE  = 2'b01,
    REG_PEND  = 2'b10,
    REG_LEVEL = 2'b11
  } reg_addr_e;

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser plus tick-sampled 3-deep history per pin; the debounced
// level only moves when every history entry agrees.
module gpio_debounce
  import gpio_irq_pkg::*;
#(
  parameter int unsigned WIDTH = GPIO_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] level_o
);

  logic [WIDTH-1:0]                sync1_q, sync2_q;
  logic [DEB_HIST-1:0][WIDTH-1:0]  hist_q;
  logic [WIDTH-1:0]                level_q, level_d;
  logic [WIDTH-1:0]                all_ones, all_zeros;

  always_comb begin
    all_ones  = '1;
    all_zeros = '1;
    for (int unsigned i = 0; i < DEB_HIST; i++) begin
      all_ones  = all_ones & hist_q[i];
      all_zeros = all_zeros & ~hist_q[i];
    end
    level_d = (level_q & ~all_zeros) | all_ones;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      level_q <= '0;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
      if (tick_i) begin
        hist_q <= {hist_q[DEB_HIST-2:0], sync2_q};
      end
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO input interrupt controller: debounced per-pin edge detect into W1C pending
// bits, one registered level interrupt, 2-bit address register interface.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int unsigned WIDTH   = GPIO_WIDTH,
  parameter int unsigned DEB_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chip_select,
  input  logic             write_enable,
  input  logic [1:0]       addr,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic [WIDTH-1:0] pins_in,
  output logic             irq
);

  localparam logic [15:0] PRESC_MAX = 16'(DEB_DIV - 1);

  logic [15:0]      presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] level, level_prev_q;
  logic [WIDTH-1:0] en_q, en_d, edge_sel_q, edge_sel_d, pend_q, pend_d;
  logic [WIDTH-1:0] rise, fall, evt, clr_mask;
  logic             irq_q;
  logic             wr_en, rd_en;
  reg_addr_e        reg_sel;

  assign tick    = (presc_q == PRESC_MAX);
  assign presc_d = tick ? '0 : presc_q + 16'd1;
  assign reg_sel = reg_addr_e'(addr);
  assign wr_en   = chip_select & write_enable;
  assign rd_en   = chip_select & ~write_enable;

  gpio_debounce #(
    .WIDTH(WIDTH)
  ) u_deb (
    .clk_i  (clk),
    .rst_ni (rst),
    .tick_i (tick),
    .pins_i (pins_in),
    .level_o(level)
  );

  always_comb begin
    en_d       = en_q;
    edge_sel_d = edge_sel_q;
    clr_mask   = '0;
    if (wr_en) begin
      case (reg_sel)
        REG_EN:   en_d       = write_data[WIDTH-1:0];
        REG_EDGE: edge_sel_d = write_data[WIDTH-1:0];
        REG_PEND: clr_mask   = write_data[WIDTH-1:0];
        default:  ;
      endcase
    end
    rise   = level & ~level_prev_q;
    fall   = ~level & level_prev_q;
    evt    = en_q & ((edge_sel_q & rise) | (~edge_sel_q & fall));
    // OR-ing the event in after the clear lets a same-cycle event win over W1C.
    pend_d = (pend_q & ~clr_mask) | evt;
  end

  always_comb begin
    read_data = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_EN:    read_data[WIDTH-1:0] = en_q;
        REG_EDGE:  read_data[WIDTH-1:0] = edge_sel_q;
        REG_PEND:  read_data[WIDTH-1:0] = pend_q;
        REG_LEVEL: read_data[WIDTH-1:0] = level;
        default:   read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q      <= '0;
      level_prev_q <= '0;
      en_q         <= '0;
      edge_sel_q   <= '0;
      pend_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      level_prev_q <= level;
      en_q         <= en_d;
      edge_sel_q   <= edge_sel_d;
      pend_q       <= pend_d;
      irq_q        <= |pend_q;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: register table, directed latency/corner sequences,
// and randomized traffic against a queue-based reference model (DEB_DIV=1 instance).
module tb_gpio_irq;
  import gpio_irq_pkg::*;

  localparam int unsigned DA = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [2] = '{1'b0, 1'b0};
  logic        cs    [2] = '{1'b0, 1'b0};
  logic        we    [2] = '{1'b0, 1'b0};
  logic [1:0]  addr  [2] = '{2'b00, 2'b00};
  logic [31:0] wd    [2] = '{32'h0, 32'h0};
  logic [31:0] pins  [2] = '{32'hFFFF_FFFF, 32'h0};
  logic [31:0] rd    [2];
  logic        irq_w [2];

  gpio_irq #(.WIDTH(32), .DEB_DIV(DA)) u_dut_a (
    .clk(clk), .rst(rst_v[0]), .chip_select(cs[0]), .write_enable(we[0]),
    .addr(addr[0]), .write_data(wd[0]), .read_data(rd[0]), .pins_in(pins[0]), .irq(irq_w[0])
  );

  gpio_irq #(.WIDTH(32), .DEB_DIV(4)) u_dut_b (
    .clk(clk), .rst(rst_v[1]), .chip_select(cs[1]), .write_enable(we[1]),
    .addr(addr[1]), .write_data(wd[1]), .read_data(rd[1]), .pins_in(pins[1]), .irq(irq_w[1])
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: pin delay line, last-3 tick samples, level history.
  logic [31:0] m_sync [$] = '{32'h0, 32'h0};
  logic [31:0] m_samp [$] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] m_lvl  [$] = '{32'h0, 32'h0};
  logic [31:0] m_en = '0, m_edge = '0, m_pend = '0;
  logic        m_irq = 1'b0;
  int unsigned m_cyc = 0;

  always @(posedge clk) begin : model
    logic [31:0] cur, prev, a1, a0, ev, clr, sync2;
    logic        tick;
    if (!rst_v[0]) begin
      m_sync = '{32'h0, 32'h0};
      m_samp = '{32'h0, 32'h0, 32'h0};
      m_lvl  = '{32'h0, 32'h0};
      m_en = '0; m_edge = '0; m_pend = '0; m_irq = 1'b0; m_cyc = 0;
    end else begin
      tick  = ((m_cyc % DA) == DA - 1);
      m_cyc = (m_cyc + 1) % DA;
      sync2 = m_sync[1];
      cur   = m_lvl[0];
      prev  = m_lvl[1];
      a1    = m_samp[0] & m_samp[1] & m_samp[2];
      a0    = ~(m_samp[0] | m_samp[1] | m_samp[2]);
      ev    = m_en & ((m_edge & cur & ~prev) | (~m_edge & ~cur & prev));
      clr   = (cs[0] && we[0] && addr[0] == REG_PEND) ? wd[0] : 32'h0;
      m_irq  = (m_pend != 0);
      m_pend = (m_pend & ~clr) | ev;
      m_lvl.push_front((cur & ~a0) | a1);
      void'(m_lvl.pop_back());
      if (tick) begin
        m_samp.push_front(sync2);
        void'(m_samp.pop_back());
      end
      m_sync.push_front(pins[0]);
      void'(m_sync.pop_back());
      if (cs[0] && we[0] && addr[0] == REG_EN)   m_en   = wd[0];
      if (cs[0] && we[0] && addr[0] == REG_EDGE) m_edge = wd[0];
    end
  end

  function automatic logic [31:0] model_rd();
    if (!(cs[0] && !we[0])) return 32'h0;
    case (addr[0])
      REG_EN:   return m_en;
      REG_EDGE: return m_edge;
      REG_PEND: return m_pend;
      default:  return m_lvl[0];
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int unsigned u, input reg_addr_e a, input logic [31:0] d);
    cs[u] = 1'b1; we[u] = 1'b1; addr[u] = a; wd[u] = d;
    cyc();
    cs[u] = 1'b0; we[u] = 1'b0;
  endtask

  task automatic rdchk(input int unsigned u, input reg_addr_e a, input logic [31:0] exp,
                       input string name);
    cs[u] = 1'b1; we[u] = 1'b0; addr[u] = a;
    #1;
    chk(name, rd[u], exp);
  endtask

  task automatic irqchk(input int unsigned u, input logic exp, input string name);
    chk(name, {31'h0, irq_w[u]}, {31'h0, exp});
  endtask

  typedef struct {
    logic        cs_f;
    logic        we_f;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, REG_EN,    32'hA5A5_5A5A, 32'h0,         "tbl_wr_en"};
    tbl[1]  = '{1'b1, 1'b0, REG_EN,    32'h0,         32'hA5A5_5A5A, "tbl_rd_en"};
    tbl[2]  = '{1'b1, 1'b1, REG_EDGE,  32'h0F0F_00FF, 32'h0,         "tbl_wr_edge"};
    tbl[3]  = '{1'b1, 1'b0, REG_EDGE,  32'h0,         32'h0F0F_00FF, "tbl_rd_edge"};
    tbl[4]  = '{1'b0, 1'b0, REG_EN,    32'h0,         32'h0,         "tbl_nocs_rd"};
    tbl[5]  = '{1'b1, 1'b1, REG_LEVEL, 32'hFFFF_FFFF, 32'h0,         "tbl_wr_level"};
    tbl[6]  = '{1'b1, 1'b0, REG_LEVEL, 32'h0,         32'h0,         "tbl_rd_level"};
    tbl[7]  = '{1'b1, 1'b1, REG_PEND,  32'hFFFF_FFFF, 32'h0,         "tbl_wr_pend"};
    tbl[8]  = '{1'b1, 1'b0, REG_PEND,  32'h0,         32'h0,         "tbl_rd_pend"};
    tbl[9]  = '{1'b1, 1'b0, REG_EN,    32'h0,         32'hA5A5_5A5A, "tbl_rd_en_kept"};
    tbl[10] = '{1'b1, 1'b1, REG_EN,    32'h0,         32'h0,         "tbl_wr_en0"};
    tbl[11] = '{1'b1, 1'b0, REG_EN,    32'h0,         32'h0,         "tbl_rd_en0"};
    tbl[12] = '{1'b0, 1'b1, REG_EN,    32'hFFFF_FFFF, 32'h0,         "tbl_nocs_wr"};
    tbl[13] = '{1'b1, 1'b0, REG_EN,    32'h0,         32'h0,         "tbl_rd_en_nocs"};
    tbl[14] = '{1'b1, 1'b1, REG_EDGE,  32'h0,         32'h0,         "tbl_wr_edge0"};
    tbl[15] = '{1'b1, 1'b0, REG_EDGE,  32'h0,         32'h0,         "tbl_rd_edge0"};

    // Reset with all pins high: every register reads 0, irq low.
    for (int unsigned i = 0; i < 4; i++) begin
      cyc();
      rdchk(0, reg_addr_e'(i), 32'h0, "rst_reg");
      irqchk(0, 1'b0, "rst_irq");
    end
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    for (int unsigned k = 1; k <= 6; k++) begin
      cyc();
      rdchk(0, REG_LEVEL, (k >= 6) ? 32'hFFFF_FFFF : 32'h0, "rel_level");
    end
    cycles(4);
    rdchk(0, REG_PEND, 32'h0, "rel_pend");
    irqchk(0, 1'b0, "rel_irq");

    // Register access table.
    pins[0] = 32'h0;
    cycles(10);
    for (int unsigned i = 0; i < 16; i++) begin
      cs[0] = tbl[i].cs_f; we[0] = tbl[i].we_f; addr[0] = tbl[i].a; wd[0] = tbl[i].d;
      #1;
      chk(tbl[i].name, rd[0], tbl[i].exp);
      cyc();
    end
    cs[0] = 1'b0; we[0] = 1'b0;

    // Rising edge on bit 0: PEND at cycle 7, irq at cycle 8.
    wr(0, REG_EN, 32'h1);
    wr(0, REG_EDGE, 32'h1);
    cyc();
    pins[0][0] = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      cyc();
      rdchk(0, REG_PEND, (k >= 7) ? 32'h1 : 32'h0, "rise_pend");
      irqchk(0, k >= 8, "rise_irq");
    end
    pins[0][0] = 1'b0;
    cycles(10);
    rdchk(0, REG_PEND, 32'h1, "fall_ignored");
    wr(0, REG_PEND, 32'hFFFF_FFFF);
    rdchk(0, REG_PEND, 32'h0, "w1c_all_pend");
    irqchk(0, 1'b1, "w1c_all_irq_lag");
    cyc();
    irqchk(0, 1'b0, "w1c_all_irq");

    // Falling edge on bit 3 plus W1C.
    wr(0, REG_EN, 32'h8);
    wr(0, REG_EDGE, 32'h0);
    pins[0][3] = 1'b1;
    cycles(10);
    rdchk(0, REG_PEND, 32'h0, "fall_no_rise");
    pins[0][3] = 1'b0;
    cycles(7);
    rdchk(0, REG_PEND, 32'h8, "fall_pend");
    cyc();
    irqchk(0, 1'b1, "fall_irq");
    wr(0, REG_PEND, 32'h8);
    rdchk(0, REG_PEND, 32'h0, "fall_w1c_pend");
    irqchk(0, 1'b1, "fall_w1c_irq_lag");
    cyc();
    irqchk(0, 1'b0, "fall_w1c_irq");

    // W1C of bit 2 on the exact cycle its event lands: set wins.
    wr(0, REG_EN, 32'h4);
    wr(0, REG_EDGE, 32'h4);
    cyc();
    pins[0][2] = 1'b1;
    cycles(6);
    wr(0, REG_PEND, 32'h4);
    rdchk(0, REG_PEND, 32'h4, "collide_pend");
    cyc();
    irqchk(0, 1'b1, "collide_irq");
    cycles(3);
    irqchk(0, 1'b1, "collide_irq_hold");
    rdchk(0, REG_PEND, 32'h4, "collide_pend_hold");

    // Reset while history holds 2 of 3 samples high.
    pins[0] = 32'h0;
    cycles(10);
    pins[0] = 32'h80;
    cycles(4);
    rst_v[0] = 1'b0;
    cyc();
    rst_v[0] = 1'b1;
    for (int unsigned k = 1; k <= 6; k++) begin
      cyc();
      rdchk(0, REG_LEVEL, (k >= 6) ? 32'h80 : 32'h0, "midrst_level");
    end
    rdchk(0, REG_PEND, 32'h0, "midrst_pend");
    rdchk(0, REG_EN, 32'h0, "midrst_en");

    // Bounce filter on the DEB_DIV=4 instance.
    wr(1, REG_EN, 32'h20);
    wr(1, REG_EDGE, 32'h20);
    for (int unsigned c = 0; c < 40; c++) begin
      if (c % 4 == 0) pins[1][5] = ~pins[1][5];
      cyc();
      rdchk(1, REG_LEVEL, 32'h0, "bounce_level");
    end
    rdchk(1, REG_PEND, 32'h0, "bounce_pend");
    pins[1][5] = 1'b1;
    cycles(20);
    rdchk(1, REG_LEVEL, 32'h20, "settle_level");
    rdchk(1, REG_PEND, 32'h20, "settle_pend");
    irqchk(1, 1'b1, "settle_irq");

    // Randomized traffic against the reference model.
    cs[0] = 1'b0; we[0] = 1'b0;
    for (int unsigned n = 0; n < 3000; n++) begin
      cyc();
      chk("rand_rdata", rd[0], model_rd());
      irqchk(0, m_irq, "rand_irq");
      rst_v[0] = ($urandom_range(0, 299) != 0);
      cs[0]    = ($urandom_range(0, 3) != 0);
      we[0]    = ($urandom_range(0, 2) == 0);
      addr[0]  = 2'($urandom_range(0, 3));
      wd[0]    = $urandom;
      pins[0]  = pins[0] ^ ($urandom & $urandom & $urandom & $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
